sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Three-way arbiter for a 16-bit asynchronous SRAM: video, CPU and JTAG loader.
// Each access is a fixed IDLE -> ACC -> END sequence with fully registered SRAM strobes.
module sram_arbiter #(
    parameter int ADDR_W = 18
) (
    input  logic              clk25,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    input  logic              jtg_req,
    input  logic              jtg_we,
    input  logic [1:0]        jtg_be,
    input  logic [ADDR_W-1:0] jtg_addr,
    input  logic [15:0]       jtg_wdata,
    output logic              jtg_ack,
    output logic [15:0]       rdata,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [15:0]       ram_dq_i,
    output logic [15:0]       ram_dq_o,
    output logic              ram_dq_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_END  = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_JTG  = 2'd3;

    // Round-robin pointer between CPU (0) and JTAG (1).
    localparam logic PTR_CPU = 1'b0;
    localparam logic PTR_JTG = 1'b1;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              lb_n_q, lb_n_d;
    logic              ub_n_q, ub_n_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              vid_ack_q, vid_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              jtg_ack_q, jtg_ack_d;

    logic              grant;
    logic [1:0]        win_code;
    logic              win_we;
    logic [1:0]        win_be;
    logic [ADDR_W-1:0] win_addr;
    logic [15:0]       win_wdata;

    // Winner selection from the requests sampled at this edge.
    always_comb begin
        grant     = 1'b0;
        win_code  = OWN_NONE;
        win_we    = 1'b0;
        win_be    = 2'b11;
        win_addr  = '0;
        win_wdata = '0;
        ptr_d     = ptr_q;
        if (vid_req) begin
            grant    = 1'b1;
            win_code = OWN_VID;
            win_addr = vid_addr;
        end else if (cpu_req && (!jtg_req || ptr_q == PTR_CPU)) begin
            grant     = 1'b1;
            win_code  = OWN_CPU;
            win_we    = cpu_we;
            win_be    = cpu_be;
            win_addr  = cpu_addr;
            win_wdata = cpu_wdata;
            ptr_d     = PTR_JTG;
        end else if (jtg_req) begin
            grant     = 1'b1;
            win_code  = OWN_JTG;
            win_we    = jtg_we;
            win_be    = jtg_be;
            win_addr  = jtg_addr;
            win_wdata = jtg_wdata;
            ptr_d     = PTR_CPU;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        dq_o_d    = dq_o_q;
        dq_oe_d   = dq_oe_q;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        lb_n_d    = 1'b1;
        ub_n_d    = 1'b1;
        rdata_d   = rdata_q;
        vid_ack_d = 1'b0;
        cpu_ack_d = 1'b0;
        jtg_ack_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                owner_d = OWN_NONE;
                dq_oe_d = 1'b0;
                if (grant) begin
                    state_d = S_ACC;
                    owner_d = win_code;
                    we_d    = win_we;
                    addr_d  = win_addr;
                    dq_o_d  = win_wdata;
                    dq_oe_d = win_we;
                    ce_n_d  = 1'b0;
                    oe_n_d  = win_we;
                    we_n_d  = !win_we;
                    lb_n_d  = !win_be[0];
                    ub_n_d  = !win_be[1];
                end
            end
            S_ACC: begin
                state_d = S_END;
                if (!we_q) begin
                    rdata_d = ram_dq_i;
                end
                vid_ack_d = (owner_q == OWN_VID);
                cpu_ack_d = (owner_q == OWN_CPU);
                jtg_ack_d = (owner_q == OWN_JTG);
            end
            S_END: begin
                // Write data stays driven through END for hold time, released here.
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                dq_oe_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                dq_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_CPU;
            owner_q   <= OWN_NONE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            dq_o_q    <= '0;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            rdata_q   <= '0;
            vid_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            jtg_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= (state_q == S_IDLE) ? ptr_d : ptr_q;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            dq_o_q    <= dq_o_d;
            dq_oe_q   <= dq_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            lb_n_q    <= lb_n_d;
            ub_n_q    <= ub_n_d;
            rdata_q   <= rdata_d;
            vid_ack_q <= vid_ack_d;
            cpu_ack_q <= cpu_ack_d;
            jtg_ack_q <= jtg_ack_d;
        end
    end

    assign vid_ack   = vid_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign jtg_ack   = jtg_ack_q;
    assign rdata     = rdata_q;
    assign ram_addr  = addr_q;
    assign ram_dq_o  = dq_o_q;
    assign ram_dq_oe = dq_oe_q;
    assign ram_ce_n  = ce_n_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_we_n  = we_n_q;
    assign ram_lb_n  = lb_n_q;
    assign ram_ub_n  = ub_n_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: table of single accesses against a byte-lane
// SRAM model, plus hand sequences for back-to-back, arbitration order and reset.
module tb_sram_arbiter;

    localparam int ADDR_W = 18;

    logic              clk25;
    logic              reset_n;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic              cpu_ack;
    logic              jtg_req;
    logic              jtg_we;
    logic [1:0]        jtg_be;
    logic [ADDR_W-1:0] jtg_addr;
    logic [15:0]       jtg_wdata;
    logic              jtg_ack;
    logic [15:0]       rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_dq_i;
    logic [15:0]       ram_dq_o;
    logic              ram_dq_oe;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;
    logic              ram_lb_n;
    logic              ram_ub_n;
    logic [1:0]        owner;

    sram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk25     (clk25),
        .reset_n   (reset_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_ack   (vid_ack),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .jtg_req   (jtg_req),
        .jtg_we    (jtg_we),
        .jtg_be    (jtg_be),
        .jtg_addr  (jtg_addr),
        .jtg_wdata (jtg_wdata),
        .jtg_ack   (jtg_ack),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_dq_i  (ram_dq_i),
        .ram_dq_o  (ram_dq_o),
        .ram_dq_oe (ram_dq_oe),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram_lb_n  (ram_lb_n),
        .ram_ub_n  (ram_ub_n),
        .owner     (owner)
    );

    // ---------------- clock / reset ----------------
    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    // ---------------- SRAM model (256 words, low address byte) ----------------
    logic [15:0] mem [0:255];
    assign ram_dq_i = mem[ram_addr[7:0]];

    always @(posedge clk25) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h34] <= 16'hBEEF;
            mem[8'h56] <= 16'h1111;
            mem[8'h78] <= 16'h7777;
        end else if (!ram_ce_n && !ram_we_n) begin
            if (!ram_lb_n) mem[ram_addr[7:0]][7:0]  <= ram_dq_o[7:0];
            if (!ram_ub_n) mem[ram_addr[7:0]][15:8] <= ram_dq_o[15:8];
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " strobes"}, {27'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}, 32'h1f);
        check({tag, " dq_oe"}, {31'd0, ram_dq_oe}, 32'd0);
        check({tag, " dq_o"}, {16'd0, ram_dq_o}, 32'd0);
        check({tag, " addr"}, {14'd0, ram_addr}, 32'd0);
        check({tag, " rdata"}, {16'd0, rdata}, 32'd0);
        check({tag, " owner"}, {30'd0, owner}, 32'd0);
        check({tag, " acks"}, {29'd0, jtg_ack, cpu_ack, vid_ack}, 32'd0);
    endtask

    task automatic clear_reqs();
        vid_req = 1'b0; cpu_req = 1'b0; jtg_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk25);
        reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]        who;      // 1 video, 2 CPU, 3 JTAG
        logic              we;
        logic [1:0]        be;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
        logic              exp_lb_n;
        logic              exp_ub_n;
        logic              exp_oe_n;
        logic              exp_we_n;
        logic [15:0]       exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic drive_one(input vec_t v);
        clear_reqs();
        case (v.who)
            2'd1: begin vid_req = 1'b1; vid_addr = v.addr; end
            2'd2: begin
                cpu_req = 1'b1; cpu_we = v.we; cpu_be = v.be;
                cpu_addr = v.addr; cpu_wdata = v.wdata;
            end
            default: begin
                jtg_req = 1'b1; jtg_we = v.we; jtg_be = v.be;
                jtg_addr = v.addr; jtg_wdata = v.wdata;
            end
        endcase
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        drive_one(v);
        @(negedge clk25);
        check($sformatf("v%0d acc ce_n", i), {31'd0, ram_ce_n}, 32'd0);
        check($sformatf("v%0d acc addr", i), {14'd0, ram_addr}, {14'd0, v.addr});
        check($sformatf("v%0d acc owner", i), {30'd0, owner}, {30'd0, v.who});
        check($sformatf("v%0d acc lb/ub/oe/we", i), {28'd0, ram_lb_n, ram_ub_n, ram_oe_n, ram_we_n},
              {28'd0, v.exp_lb_n, v.exp_ub_n, v.exp_oe_n, v.exp_we_n});
        check($sformatf("v%0d acc dq_oe", i), {31'd0, ram_dq_oe}, {31'd0, v.we});
        if (v.we) check($sformatf("v%0d acc dq_o", i), {16'd0, ram_dq_o}, {16'd0, v.wdata});
        check($sformatf("v%0d acc acks", i), {29'd0, jtg_ack, cpu_ack, vid_ack}, 32'd0);
        @(negedge clk25);
        check($sformatf("v%0d end acks", i), {29'd0, jtg_ack, cpu_ack, vid_ack}, 32'(1) << (v.who - 2'd1));
        check($sformatf("v%0d end strobes", i), {27'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}, 32'h1f);
        check($sformatf("v%0d end dq_oe", i), {31'd0, ram_dq_oe}, {31'd0, v.we});
        check($sformatf("v%0d end addr", i), {14'd0, ram_addr}, {14'd0, v.addr});
        check($sformatf("v%0d end rdata", i), {16'd0, rdata}, {16'd0, v.exp_rdata});
        check($sformatf("v%0d end owner", i), {30'd0, owner}, {30'd0, v.who});
        clear_reqs();
        @(negedge clk25);
        check($sformatf("v%0d idle owner", i), {30'd0, owner}, 32'd0);
        check($sformatf("v%0d idle dq_oe", i), {31'd0, ram_dq_oe}, 32'd0);
        check($sformatf("v%0d idle acks", i), {29'd0, jtg_ack, cpu_ack, vid_ack}, 32'd0);
    endtask

    int         ack_cyc [4];
    logic [1:0] exp_lo [3];
    logic [1:0] exp_hi [6];

    initial begin
        //            who   we    be     addr       wdata     lb    ub    oe    we_n  rdata
        vecs[0] = '{2'd2, 1'b0, 2'b11, 18'h01234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF};
        vecs[1] = '{2'd3, 1'b1, 2'b10, 18'h00056, 16'hA55A, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF};
        vecs[2] = '{2'd2, 1'b0, 2'b11, 18'h00056, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA511};
        vecs[3] = '{2'd1, 1'b0, 2'b00, 18'h00078, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777};
        vecs[4] = '{2'd2, 1'b1, 2'b01, 18'h00078, 16'h12AB, 1'b0, 1'b1, 1'b1, 1'b0, 16'h7777};
        vecs[5] = '{2'd3, 1'b0, 2'b11, 18'h00078, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h77AB};
        vecs[6] = '{2'd2, 1'b1, 2'b00, 18'h00034, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h77AB};
        vecs[7] = '{2'd3, 1'b0, 2'b01, 18'h00034, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF};
        exp_lo = '{2'd2, 2'd3, 2'd2};
        exp_hi = '{2'd1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd2};

        reset_n = 1'b0;
        clear_reqs();
        vid_addr = '0;
        cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0; cpu_wdata = '0;
        jtg_we = 1'b0; jtg_be = 2'b00; jtg_addr = '0; jtg_wdata = '0;
        repeat (3) @(negedge clk25);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk25);
        check_reset_vals("idle after reset");

        for (int i = 0; i < 8; i++) run_vec(i);

        // Continuous CPU reads: one ack every 3 cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 18'h00034;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk25);
            check($sformatf("b2b%0d acc owner", k), {30'd0, owner}, 32'd2);
            check($sformatf("b2b%0d acc ce/oe", k), {30'd0, ram_ce_n, ram_oe_n}, 32'd0);
            @(negedge clk25);
            check($sformatf("b2b%0d end ack", k), {31'd0, cpu_ack}, 32'd1);
            check($sformatf("b2b%0d end owner", k), {30'd0, owner}, 32'd2);
            ack_cyc[k] = cyc;
            if (k > 0) check($sformatf("b2b%0d ack spacing", k), 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
            @(negedge clk25);
            check($sformatf("b2b%0d idle ack", k), {31'd0, cpu_ack}, 32'd0);
            if (k == 3) cpu_req = 1'b0;
        end
        @(negedge clk25);
        check("b2b stays idle", {31'd0, ram_ce_n}, 32'd1);

        // Round robin without video, both held continuously.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 18'h00034;
        jtg_req = 1'b1; jtg_we = 1'b0; jtg_be = 2'b11; jtg_addr = 18'h00056;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk25);
            check($sformatf("rr%0d owner", g), {30'd0, owner}, {30'd0, exp_lo[g]});
            @(negedge clk25);
            check($sformatf("rr%0d ack", g), {29'd0, jtg_ack, cpu_ack, vid_ack}, 32'(1) << (exp_lo[g] - 2'd1));
            @(negedge clk25);
            if (g == 2) clear_reqs();
        end

        // All three requesting; each drops its req for one arbitration after its ack.
        do_reset();
        vid_req = 1'b1; vid_addr = 18'h00078;
        cpu_req = 1'b1; jtg_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk25);
            check($sformatf("arb%0d owner", g), {30'd0, owner}, {30'd0, exp_hi[g]});
            vid_req = 1'b1; cpu_req = 1'b1; jtg_req = 1'b1;
            @(negedge clk25);
            check($sformatf("arb%0d ack", g), {29'd0, jtg_ack, cpu_ack, vid_ack}, 32'(1) << (exp_hi[g] - 2'd1));
            if (vid_ack) vid_req = 1'b0;
            if (cpu_ack) cpu_req = 1'b0;
            if (jtg_ack) jtg_req = 1'b0;
            @(negedge clk25);
        end
        clear_reqs();
        @(negedge clk25);

        // Reset in the middle of a write access.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 18'h00099; cpu_wdata = 16'h5A5A;
        @(posedge clk25);
        #5;
        check("rst-acc we_n low", {31'd0, ram_we_n}, 32'd0);
        check("rst-acc dq_oe high", {31'd0, ram_dq_oe}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst-acc async");
        clear_reqs();
        @(negedge clk25);
        @(negedge clk25);
        check("rst-acc no ack", {29'd0, jtg_ack, cpu_ack, vid_ack}, 32'd0);

        // First edge after release arbitrates a pending request.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 18'h00056;
        reset_n = 1'b1;
        @(negedge clk25);
        check("post-rst acc owner", {30'd0, owner}, 32'd2);
        check("post-rst acc ce_n", {31'd0, ram_ce_n}, 32'd0);
        @(negedge clk25);
        check("post-rst ack", {31'd0, cpu_ack}, 32'd1);
        check("post-rst rdata", {16'd0, rdata}, 32'h1111);
        clear_reqs();
        @(negedge clk25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
